hamming_dec_pipe: RTL and testbench
===================================

Name: hamming_dec_pipe

Overview:
- Pipelined SECDED Hamming decoder and corrector that consumes the codewords produced by the team's Hamming encoder, `hamming_enc`.
- Two register stages with a valid/ready handshake on both sides.
- Sits on the read path of ECC-protected storage and links.
- Returns corrected data, an error class, the syndrome, and saturating error-statistics counters.

Parameters:
- K, 8, data width; must equal the encoder's K.
- P0_LSB, 1, overall-parity bit position; must equal the encoder's P0_LSB.
- CNT_W, 16, width of each error counter.
- m, derived, number of Hamming parity bits: the smallest m with 2**m >= m+K+1.
- n, derived, m+K.

Ports:
- clk_i  in  1  rising-edge clock
- rst_ni  in  1  synchronous reset, active-low
- in_valid_i  in  1  input codeword valid
- in_ready_o  out  1  decoder can accept a codeword
- cw_i  in  n+1  codeword from the encoder
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts the result
- d_o  out  K  corrected data
- err_o  out  2  0=NONE, 1=CORR, 2=UNCORR
- syn_o  out  m  syndrome of the delivered word
- clr_cnt_i  in  1  synchronous clear of both counters
- corr_cnt_o  out  CNT_W  count of delivered CORR results
- uncorr_cnt_o  out  CNT_W  count of delivered UNCORR results

Behaviour:
- Reset is the only asynchronous-free path: clk_i and rst_ni only, synchronous active-low.
  - When rst_ni=0 at a clock edge: both stage valids, out_valid_o, d_o, err_o, syn_o and both counters go to 0.
  - in_ready_o reads 1 from the first cycle after reset.
  - A reset in mid-stream discards all in-flight words; no partial output is produced.
- Codeword layout:
  - P0_LSB=1: Hamming position i (1..n) is cw_i[i]; overall parity p0 is cw_i[0].
  - P0_LSB=0: position i is cw_i[i-1]; p0 is cw_i[n].
  - Parity bits sit at power-of-two positions.
  - Data bit j is the j-th non-power-of-two position, counted in ascending order.
- Stage 1 (capture when in_valid_i && in_ready_o):
  - Register the Hamming positions.
  - Compute syndrome bit b as the XOR of every position whose index has bit b set.
  - Compute overall parity q as the XOR of all n+1 bits.
  - Register s and q.
- Stage 2 classification:
  - s=0, q=0: NONE.
  - s=0, q=1: CORR; the error is in p0 and the data is unchanged.
  - s!=0, q=1, s<=n: CORR; flip position s.
  - s!=0, q=1, s>n: UNCORR; data is passed through uncorrected.
  - s!=0, q=0: UNCORR (double error); data is passed through uncorrected.
- Outputs d_o, err_o and syn_o are registered and held stable while out_valid_o && !out_ready_i.
- Latency: 2 cycles from input handshake to out_valid_o, with no stalls.
- Throughput: 1 word per cycle while out_ready_i=1.
- Flow control:
  - Stage 2 advances when it is empty or out_ready_i=1.
  - Stage 1 advances when it is empty or stage 2 advances.
  - in_ready_o = !s1_valid || s2_advance (combinational from out_ready_i).
  - No data is dropped or duplicated, and word order is preserved.
- Counters:
  - Increment only on an output handshake with the matching err_o class.
  - Saturate at 2**CNT_W-1.
  - clr_cnt_i takes priority: on a cycle where clear and increment coincide, the counter becomes 0 and the increment is lost.

Optional Feature:
- Macro: HAMMING_DEC_ERR_INJ_EN.
- When defined:
  - Adds port inj_i (in, n+1 bits).
  - inj_i is XORed into cw_i at stage-1 capture, used for fault-injection testing.
- When undefined: the port is absent and the datapath is identical to inj_i=0.

Decomposition:
- Package hamming_pkg holds:
  - function calc_m(K), shared with the encoder;
  - enum err_e {ERR_NONE=0, ERR_CORR=1, ERR_UNCORR=2};
  - function is_pow2(i).
- Sub-module hamming_syndrome: purely combinational, takes the n+1-bit codeword plus P0_LSB and returns s[m:1] and q.
  - Reused later by a scrubber.

Test Plan (K=8, m=4, n=12, P0_LSB=1):
- Encode 8'hA5 and push the clean codeword -> 2 cycles later out_valid_o=1, d_o=8'hA5, err_o=NONE, syn_o=0; counters unchanged.
- Encode 8'hA5, flip cw bit 5 -> d_o=8'hA5, err_o=CORR, syn_o=5, corr_cnt_o=1.
- Encode 8'h3C, flip cw bit 0 (p0) only -> d_o=8'h3C, err_o=CORR, syn_o=0.
- Encode 8'h3C, flip cw bits 3 and 6 -> err_o=UNCORR, syn_o=5, uncorr_cnt_o=1, d_o equal to the uncorrected data field.
- Hold out_ready_i=0 while pushing words 1,2,3 -> in_ready_o drops after 2 accepts; release -> outputs 1,2,3 in order on consecutive cycles.
- Run with CNT_W=2 and send 5 CORR words -> corr_cnt_o=3.
  - Then assert clr_cnt_i on the same cycle as a CORR handshake -> corr_cnt_o=0.
  - Then pulse rst_ni low with 2 words in flight -> no out_valid_o afterwards.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED Hamming encoder/decoder family.
package hamming_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_CORR   = 2'd1,
        ERR_UNCORR = 2'd2
    } err_e;

    // Smallest m with 2**m >= m + k + 1.
    function automatic int unsigned calc_m(input int unsigned k);
        int unsigned r;
        r = 0;
        for (int i = 20; i >= 1; i--) begin
            if ((1 << i) >= i + k + 1) begin
                r = i;
            end
        end
        return r;
    endfunction

    function automatic logic is_pow2(input int unsigned i);
        return (i != 0) && ((i & (i - 1)) == 0);
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity computation for an n+1-bit SECDED codeword.
// Also exposes the codeword re-ordered into Hamming positions 1..n.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int unsigned  K      = 8,
    parameter int unsigned  P0_LSB = 1,
    localparam int unsigned M      = calc_m(K),
    localparam int unsigned N      = M + K
) (
    input  logic [N:0]   cw_i,
    output logic [N:1]   pos_o,
    output logic [M-1:0] s_o,
    output logic         q_o
);

    always_comb begin
        pos_o = '0;
        s_o   = '0;
        for (int i = 1; i <= N; i++) begin
            pos_o[i] = (P0_LSB != 0) ? cw_i[i] : cw_i[i-1];
        end
        // Bit b of the syndrome covers every position whose index has bit b set.
        for (int i = 1; i <= N; i++) begin
            for (int b = 0; b < M; b++) begin
                if (((i >> b) & 1) == 1) begin
                    s_o[b] = s_o[b] ^ pos_o[i];
                end
            end
        end
        q_o = ^cw_i;
    end

endmodule

// File: rtl/hamming_dec_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready on both sides and saturating error counters.
// Optional fault injection port inj_i when HAMMING_DEC_ERR_INJ_EN is defined.
module hamming_dec_pipe
    import hamming_pkg::*;
#(
    parameter int unsigned  K      = 8,
    parameter int unsigned  P0_LSB = 1,
    parameter int unsigned  CNT_W  = 16,
    localparam int unsigned M      = calc_m(K),
    localparam int unsigned N      = M + K
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N:0]       cw_i,
`ifdef HAMMING_DEC_ERR_INJ_EN
    input  logic [N:0]       inj_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [K-1:0]     d_o,
    output logic [1:0]       err_o,
    output logic [M-1:0]     syn_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] corr_cnt_o,
    output logic [CNT_W-1:0] uncorr_cnt_o
);

    logic [N:0]       cw_eff;
    logic [N:1]       pos_in;
    logic [M-1:0]     syn_in;
    logic             q_in;

    logic             s1_valid_q, s1_valid_d;
    logic [N:1]       s1_pos_q, s1_pos_d;
    logic [M-1:0]     s1_syn_q, s1_syn_d;
    logic             s1_par_q, s1_par_d;

    logic             s2_valid_q, s2_valid_d;
    logic [K-1:0]     d_q, d_d;
    err_e             err_q, err_d;
    logic [M-1:0]     syn_q, syn_d;

    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    logic             s1_adv, s2_adv, out_hs;
    logic             flip_en;
    err_e             cls;
    logic [N:1]       pos_fix;
    logic [K-1:0]     data_fix;
    int unsigned      j;

`ifdef HAMMING_DEC_ERR_INJ_EN
    assign cw_eff = cw_i ^ inj_i;
`else
    assign cw_eff = cw_i;
`endif

    hamming_syndrome #(
        .K      (K),
        .P0_LSB (P0_LSB)
    ) u_syndrome (
        .cw_i  (cw_eff),
        .pos_o (pos_in),
        .s_o   (syn_in),
        .q_o   (q_in)
    );

    assign s2_adv     = !s2_valid_q || out_ready_i;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign in_ready_o = s1_adv;
    assign out_hs     = s2_valid_q && out_ready_i;

    // Stage 1: capture positions, syndrome and overall parity.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pos_d   = s1_pos_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_adv) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_pos_d = pos_in;
                s1_syn_d = syn_in;
                s1_par_d = q_in;
            end
        end
    end

    // Classification of the word held in stage 1.
    always_comb begin
        cls     = ERR_UNCORR;
        flip_en = 1'b0;
        if (s1_syn_q == '0) begin
            cls = s1_par_q ? ERR_CORR : ERR_NONE;
        end else if (s1_par_q && (32'(s1_syn_q) <= N)) begin
            cls     = ERR_CORR;
            flip_en = 1'b1;
        end
    end

    // Correct the flagged position, then gather the data bits from non-power-of-two slots.
    always_comb begin
        pos_fix  = s1_pos_q;
        data_fix = '0;
        j        = 0;
        for (int i = 1; i <= N; i++) begin
            if (flip_en && (32'(s1_syn_q) == 32'(i))) begin
                pos_fix[i] = ~s1_pos_q[i];
            end
        end
        for (int i = 1; i <= N; i++) begin
            if (!is_pow2(i)) begin
                data_fix[j] = pos_fix[i];
                j           = j + 1;
            end
        end
    end

    // Stage 2: registered outputs, held while stalled.
    always_comb begin
        s2_valid_d = s2_valid_q;
        d_d        = d_q;
        err_d      = err_q;
        syn_d      = syn_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                d_d   = data_fix;
                err_d = cls;
                syn_d = s1_syn_q;
            end
        end
    end

    // Clear wins over a coincident increment.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clr_cnt_i) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_hs) begin
            if (err_q == ERR_CORR && corr_cnt_q != {CNT_W{1'b1}}) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (err_q == ERR_UNCORR && uncorr_cnt_q != {CNT_W{1'b1}}) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q   <= 1'b0;
            s1_pos_q     <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            d_q          <= '0;
            err_q        <= ERR_NONE;
            syn_q        <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_pos_q     <= s1_pos_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s2_valid_q   <= s2_valid_d;
            d_q          <= d_d;
            err_q        <= err_d;
            syn_q        <= syn_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid_o  = s2_valid_q;
    assign d_o          = d_q;
    assign err_o        = err_q;
    assign syn_o        = syn_q;
    assign corr_cnt_o   = corr_cnt_q;
    assign uncorr_cnt_o = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_dec_pipe.sv
// Bench for hamming_dec_pipe (K=8, CNT_W=2): directed cases plus random traffic vs. a reference model.
module tb_hamming_dec_pipe;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] err;
        logic [3:0] syn;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [12:0]      cw_in;
`ifdef HAMMING_DEC_ERR_INJ_EN
    logic [12:0]      inj = '0;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       d_out;
    logic [1:0]       err_out;
    logic [3:0]       syn_out;
    logic             clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    int   checks = 0;
    int   errors = 0;
    int   m_corr = 0;
    int   m_uncorr = 0;
    exp_t exp_q[$];
    exp_t cur_exp;

    always #5 clk = ~clk;

    hamming_dec_pipe #(
        .K      (8),
        .P0_LSB (1),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .cw_i         (cw_in),
`ifdef HAMMING_DEC_ERR_INJ_EN
        .inj_i        (inj),
`endif
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .d_o          (d_out),
        .err_o        (err_out),
        .syn_o        (syn_out),
        .clr_cnt_i    (clr),
        .corr_cnt_o   (corr_cnt),
        .uncorr_cnt_o (uncorr_cnt)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] encode(input logic [7:0] data);
        logic [12:0] cw;
        logic        par;
        int          j;
        cw = '0;
        j  = 0;
        for (int i = 1; i <= 12; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = data[j];
                j++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            par = 1'b0;
            for (int i = 1; i <= 12; i++) begin
                if (((i >> b) & 1) == 1) par ^= cw[i];
            end
            cw[1 << b] = par;
        end
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

    function automatic logic [7:0] field(input logic [12:0] cw);
        logic [7:0] d;
        int         j;
        d = '0;
        j = 0;
        for (int i = 1; i <= 12; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

    // Expected result from the original data and the set of flipped codeword bits.
    function automatic exp_t ref_dec(input logic [7:0] data, input logic [12:0] flips);
        exp_t        e;
        logic [12:0] cw;
        int          nflip;
        int          s;
        cw    = encode(data) ^ flips;
        nflip = 0;
        s     = 0;
        for (int i = 0; i <= 12; i++) begin
            if (flips[i]) begin
                nflip++;
                s ^= i;
            end
        end
        e.syn = s[3:0];
        if (nflip == 0) begin
            e.d = data; e.err = 2'd0;
        end else if (nflip == 1) begin
            e.d = data; e.err = 2'd1;
        end else if (nflip == 2) begin
            e.d = field(cw); e.err = 2'd2;
        end else if (s == 0) begin
            e.d = field(cw); e.err = 2'd1;
        end else if (s <= 12) begin
            e.d = field(cw ^ (13'd1 << s)); e.err = 2'd1;
        end else begin
            e.d = field(cw); e.err = 2'd2;
        end
        return e;
    endfunction

    // One clock: score any output handshake, record any input handshake, check counters.
    task automatic step();
        exp_t e;
        logic hs;
        logic popped;
        #1;
        hs     = out_valid && out_ready;
        popped = 1'b0;
        e      = '0;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", 32'(out_valid), 32'd0);
            end else begin
                e      = exp_q.pop_front();
                popped = 1'b1;
                check("d_o", 32'(d_out), 32'(e.d));
                check("err_o", 32'(err_out), 32'(e.err));
                check("syn_o", 32'(syn_out), 32'(e.syn));
            end
        end
        if (clr) begin
            m_corr   = 0;
            m_uncorr = 0;
        end else if (popped) begin
            if (e.err == 2'd1 && m_corr < CNT_MAX) m_corr++;
            if (e.err == 2'd2 && m_uncorr < CNT_MAX) m_uncorr++;
        end
        if (in_valid && in_ready) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
        check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
        check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
    endtask

    task automatic set_word(input logic [7:0] data, input logic [12:0] flips);
        cw_in   = encode(data) ^ flips;
        cur_exp = ref_dec(data, flips);
    endtask

    task automatic send(input logic [7:0] data, input logic [12:0] flips);
        set_word(data, flips);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while (exp_q.size() > 0 && guard < 30) begin
            step();
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_corr   = 0;
        m_uncorr = 0;
    endtask

    initial begin
        int guard;
        logic [12:0] fl;
        int a, b, nf;

        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;
        cw_in     = '0;
        cur_exp   = '0;
        #1;
        do_reset();

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", 32'(d_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        check("rst_syn", 32'(syn_out), 32'd0);
        check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
        check("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Clean word and two-cycle latency.
        send(8'hA5, 13'h0);
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        step();
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("clean_d", 32'(d_out), 32'h A5);
        drain();

        send(8'hA5, 13'd1 << 5);
        drain();
        check("corr_cnt_after_bit5", 32'(corr_cnt), 32'd1);

        send(8'h3C, 13'd1);
        drain();

        send(8'h3C, (13'd1 << 3) | (13'd1 << 6));
        drain();
        check("uncorr_cnt_after_double", 32'(uncorr_cnt), 32'd1);

        // Triple flip giving a syndrome beyond n.
        send(8'h5A, (13'd1 << 1) | (13'd1 << 2) | (13'd1 << 12));
        drain();

        // Backpressure: two accepts, then stall; release drains in order.
        out_ready = 1'b0;
        send(8'd1, 13'h0);
        send(8'd2, 13'h0);
        set_word(8'd3, 13'h0);
        in_valid = 1'b1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_held_d", 32'(d_out), 32'd1);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("release_valid2", 32'(out_valid), 32'd1);
        step();
        check("release_valid3", 32'(out_valid), 32'd1);
        drain();

        // Saturation with CNT_W=2.
        clr = 1'b1;
        step();
        clr = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_word(8'($urandom), 13'd1 << $urandom_range(0, 12));
            step();
        end
        drain();
        check("corr_cnt_saturated", 32'(corr_cnt), 32'd3);

        // Clear coinciding with a CORR handshake.
        send(8'h77, 13'd1 << 9);
        guard = 0;
        while (!out_valid && guard < 10) begin
            step();
            guard++;
        end
        check("clr_case_valid", 32'(out_valid), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("corr_cnt_clr_priority", 32'(corr_cnt), 32'd0);

        // Reset with two words in flight.
        send(8'h11, 13'h0);
        send(8'h22, 13'd1 << 4);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check("post_rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);

        // Random traffic with random backpressure and occasional clears.
        for (int k = 0; k < 300; k++) begin
            nf = $urandom_range(0, 2);
            fl = '0;
            a  = $urandom_range(0, 12);
            b  = (a + $urandom_range(1, 12)) % 13;
            if (nf >= 1) fl[a] = 1'b1;
            if (nf == 2) fl[b] = 1'b1;
            set_word(8'($urandom), fl);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 15) == 0);
            step();
        end
        clr = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
